flash_ctrl: RTL

Instruction-fetch responder for the core's flash port. It accepts a fetch request (`ld_flash` with the 10-bit word address `flash_addr_PC`) and reads the 32-bit word from an external SPI NOR flash using READ (0x03). It reports progress on `flash_busy` and returns the word on `dout_flash`. A one-entry last-word buffer answers repeated fetches of the same address without an SPI transaction. The block sits between the core's fetch interface and the board-level SPI flash pins.

---
 rtl/flash_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/flash_ctrl.sv
// flash_ctrl: instruction-fetch responder that reads one 32-bit word from an
// SPI NOR flash with READ (0x03). It runs SPI mode 0 with a 64-bit frame:
// an 8-bit command, a 24-bit byte address, then 32 data bits.
// A one-entry last-word buffer answers a repeated fetch of the same address
// without any SPI traffic.
module flash_ctrl #(
    parameter int          CLK_DIV   = 2,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_flash,
    input  logic [9:0]  flash_addr_PC,
    output logic        flash_busy,
    output logic [31:0] dout_flash,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;
    localparam logic [1:0] S_HIT     = 2'd3;

    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic [1:0]    state;
    logic [DW-1:0] div_cnt;    // cycles spent in the current SCK phase / recovery
    logic [5:0]    bit_cnt;    // frame bit 0..63
    logic [31:0]   tx_sh;      // remaining command/address bits, MSB next
    logic [31:0]   rx_sh;      // data bits as received, B0 in the top byte
    logic [9:0]    req_addr;
    logic [9:0]    lwb_addr;
    logic          lwb_valid;

    logic [23:0]   byte_addr;
    logic          lwb_hit;
    logic          phase_end;

    // Request decode: flash byte address (wraps at 2^24) and buffer hit check
    always_comb begin
        byte_addr = BASE_ADDR + {12'd0, flash_addr_PC, 2'b00};
        lwb_hit   = lwb_valid && (flash_addr_PC == lwb_addr);
        phase_end = (div_cnt == DIV_LAST);
    end

    assign flash_busy = (state != S_IDLE);

    // Fetch sequencer: SPI frame generation, data capture and buffer update
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            req_addr   <= '0;
            lwb_addr   <= '0;
            lwb_valid  <= 1'b0;
            dout_flash <= '0;
            spi_cs_n   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_cnt <= '0;
                    if (ld_flash) begin
                        if (lwb_hit) begin
                            state <= S_HIT;
                        end else begin
                            state    <= S_SHIFT;
                            req_addr <= flash_addr_PC;
                            bit_cnt  <= '0;
                            spi_cs_n <= 1'b0;
                            spi_sck  <= 1'b0;
                            // first command bit goes out with CS; the rest wait in tx_sh
                            spi_mosi <= 1'b0;
                            tx_sh    <= {8'h03, byte_addr} << 1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            // data phase is the upper half of the frame
                            if (bit_cnt[5]) begin
                                rx_sh <= {rx_sh[30:0], spi_miso};
                            end
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == 6'd63) begin
                                spi_cs_n <= 1'b1;
                                spi_mosi <= 1'b0;
                                state    <= S_RECOVER;
                            end else begin
                                bit_cnt  <= bit_cnt + 6'd1;
                                // tx_sh has drained to zero by the data phase
                                spi_mosi <= tx_sh[31];
                                tx_sh    <= {tx_sh[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                S_RECOVER: begin
                    if (phase_end) begin
                        div_cnt    <= '0;
                        state      <= S_IDLE;
                        dout_flash <= {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};
                        lwb_addr   <= req_addr;
                        lwb_valid  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
